// File: rtl/joystick_scanner.sv
// joystick_scanner: drives latch/pulse for the joystick shift-register board and publishes deserialised axis frames.
// Define JOYSTICK_DIR_EN to build the deadzone direction decode; otherwise dir_pos/dir_neg are tied to 0.
module joystick_scanner #(
  parameter int AXIS_BITS = 8,
  parameter int NUM_AXES = 2,
  parameter int CLK_DIV = 2,
  parameter int SCAN_GAP = 4,
  parameter int DEADZONE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic data_in,
  output logic latch,
  output logic pulse,
  output logic [NUM_AXES*AXIS_BITS-1:0] positions,
  output logic frame_valid,
  output logic changed,
  output logic [NUM_AXES-1:0] dir_pos,
  output logic [NUM_AXES-1:0] dir_neg
);
  localparam int N = NUM_AXES * AXIS_BITS;
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(N);
  localparam int GW = $clog2(SCAN_GAP + 2);
  localparam logic [AXIS_BITS-1:0] CENTRE = {1'b1, {(AXIS_BITS-1){1'b0}}};
  typedef enum logic [2:0] {LATCH, SHIFT_LO, SHIFT_HI, DONE, GAP} state_t;
  state_t state;
  logic [PW-1:0] phase;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic [N-1:0] sr;
  logic phase_end, last_bit, load;
  assign phase_end = phase == PW'(CLK_DIV - 1);
  assign last_bit = bit_cnt == BW'(N - 1);
  assign load = state == SHIFT_HI && phase_end && last_bit;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= GAP;
      phase <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sr <= '0;
      latch <= 1'b0;
      pulse <= 1'b0;
      positions <= {NUM_AXES{CENTRE}};
      frame_valid <= 1'b0;
      changed <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      changed <= 1'b0;
      phase <= (phase_end || state == DONE || state == GAP) ? '0 : phase + 1'b1;
      case (state)
        LATCH:
          if (phase_end) begin
            state <= SHIFT_LO;
            latch <= 1'b0;
            bit_cnt <= '0;
          end
        SHIFT_LO:
          if (phase_end) begin
            sr[BW'(N - 1) - bit_cnt] <= data_in;
            state <= SHIFT_HI;
            pulse <= 1'b1;
          end
        SHIFT_HI:
          if (phase_end) begin
            pulse <= 1'b0;
            state <= last_bit ? DONE : SHIFT_LO;
            bit_cnt <= last_bit ? bit_cnt : bit_cnt + 1'b1;
            // positions and the strobe become visible during the DONE cycle
            positions <= last_bit ? sr : positions;
            frame_valid <= last_bit;
            changed <= last_bit && sr != positions;
          end
        DONE: begin
          // DONE already counts as the first gap cycle
          gap_cnt <= (SCAN_GAP == 0) ? '0 : GW'(1);
          state <= (SCAN_GAP == 0 && enable) ? LATCH : GAP;
          latch <= SCAN_GAP == 0 && enable;
        end
        GAP:
          if (gap_cnt == GW'(SCAN_GAP)) begin
            state <= enable ? LATCH : GAP;
            latch <= enable;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        default: state <= GAP;
      endcase
    end
  end
`ifdef JOYSTICK_DIR_EN
  localparam logic [AXIS_BITS:0] BAND_HI = {1'b0, CENTRE} + (AXIS_BITS+1)'(DEADZONE);
  localparam logic [AXIS_BITS:0] BAND_LO = {1'b0, CENTRE} - (AXIS_BITS+1)'(DEADZONE);
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_pos <= '0;
      dir_neg <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_AXES; i++) begin
        dir_pos[i] <= {1'b0, sr[i*AXIS_BITS +: AXIS_BITS]} > BAND_HI;
        dir_neg[i] <= {1'b0, sr[i*AXIS_BITS +: AXIS_BITS]} < BAND_LO;
      end
    end
  end
`else
  assign dir_pos = '0;
  assign dir_neg = '0;
`endif
endmodule

// File: tb/tb_joystick_scanner.sv
// tb_joystick_scanner: board emulators feed frames to a default and a 10x3 scanner; results checked against a frame-level model.
module tb_joystick_scanner;
`ifdef JOYSTICK_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif
  logic clk = 0, reset = 1, enable = 1, data_in = 0;
  logic latch, pulse, frame_valid, changed;
  logic [15:0] positions;
  logic [1:0] dir_pos, dir_neg;
  logic rst2 = 1, en2 = 1, data2 = 0;
  logic latch2, pulse2, fv2, changed2;
  logic [29:0] pos2;
  logic [2:0] dp2, dn2;
  int tests = 0, fails = 0;
  bit done2 = 0;
  logic [15:0] next_frame = 16'h0000;
  logic [15:0] prev;
  logic [29:0] frames2 [4];
  typedef struct { logic [15:0] f; logic [15:0] pos; logic ch; logic [1:0] dp; logic [1:0] dn; } vec_t;
  vec_t tbl [9];

  joystick_scanner dut (.clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .latch(latch),
    .pulse(pulse), .positions(positions), .frame_valid(frame_valid), .changed(changed),
    .dir_pos(dir_pos), .dir_neg(dir_neg));
  joystick_scanner #(.AXIS_BITS(10), .NUM_AXES(3), .CLK_DIV(1), .SCAN_GAP(0)) dut2 (.clk(clk),
    .reset(rst2), .enable(en2), .data_in(data2), .latch(latch2), .pulse(pulse2), .positions(pos2),
    .frame_valid(fv2), .changed(changed2), .dir_pos(dp2), .dir_neg(dn2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Per-axis deadzone decode from the plain arithmetic rule: v > C+16 / v < C-16.
  function automatic logic [3:0] dir_model(input logic [63:0] f, input int ab, input int na, input bit pos);
    logic [3:0] r;
    longint c, v;
    r = '0;
    c = longint'(1) << (ab - 1);
    for (int i = 0; i < na; i++) begin
      v = longint'((f >> (i * ab)) & ((64'd1 << ab) - 1));
      r[i] = DIR_EN && (pos ? v > c + 16 : v < c - 16);
    end
    return r;
  endfunction

  task automatic wait_fv(input string nm, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_valid && n < 400);
    if (!frame_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: no frame_valid within 400 cycles", nm);
    end
  endtask

  task automatic run_frame(input string nm, input logic [15:0] f, input logic [15:0] ep, input logic ch,
                           input logic [1:0] dp, input logic [1:0] dn, output int n);
    next_frame = f;
    wait_fv(nm, n);
    chk({nm, " positions"}, positions, ep);
    chk({nm, " changed"}, changed, ch);
    chk({nm, " dir_pos"}, dir_pos, dp);
    chk({nm, " dir_neg"}, dir_neg, dn);
  endtask

  // Walk to the SHIFT_LO phase of bit b of a fresh frame.
  task automatic reach_bit(input string nm, input int b);
    int n, rises;
    logic pp;
    n = 0;
    rises = 0;
    pp = 1'b0;
    while (!latch && n < 200) begin tick(); n++; end
    while (rises < b && n < 400) begin
      tick();
      n++;
      if (pulse && !pp) rises++;
      pp = pulse;
    end
    while (pulse && n < 400) begin tick(); n++; end
    chk({nm, " reached"}, n < 400, 1'b1);
  endtask

  // Board model for the default DUT: capture on latch, shift on pulse rise.
  initial begin
    logic [15:0] cur;
    int idx;
    logic pl, pp;
    cur = '0; idx = 0; pl = 0; pp = 0;
    forever begin
      tick();
      if (latch && !pl) cur = next_frame;
      if (latch) idx = 0;
      else if (pulse && !pp) idx++;
      pl = latch;
      pp = pulse;
      data_in = idx < 16 ? cur[15 - idx] : 1'b0;
    end
  end

  initial begin
    logic [29:0] cur;
    int idx, fc;
    logic pl, pp;
    cur = '0; idx = 0; fc = 0; pl = 0; pp = 0;
    forever begin
      tick();
      if (latch2 && !pl) begin
        cur = frames2[fc % 4];
        fc++;
      end
      if (latch2) idx = 0;
      else if (pulse2 && !pp) idx++;
      pl = latch2;
      pp = pulse2;
      data2 = idx < 30 ? cur[29 - idx] : 1'b0;
    end
  end

  initial begin
    int n;
    logic [29:0] p2;
    frames2[0] = 30'h2AAAAAAA;
    frames2[1] = 30'h15555555;
    frames2[2] = 30'h2AAAAAAA;
    frames2[3] = 30'h3FF00200;
    p2 = '0;
    for (int i = 0; i < 3; i++) p2[i*10+9] = 1'b1;
    repeat (3) tick();
    chk("dut2 reset positions", pos2, p2);
    rst2 = 0;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!fv2 && n < 300);
      chk($sformatf("dut2 frame%0d strobe", j), fv2, 1'b1);
      chk($sformatf("dut2 frame%0d positions", j), pos2, frames2[j]);
      chk($sformatf("dut2 frame%0d changed", j), changed2, frames2[j] != p2);
      chk($sformatf("dut2 frame%0d dir_pos", j), dp2, 3'(dir_model(64'(frames2[j]), 10, 3, 1)));
      chk($sformatf("dut2 frame%0d dir_neg", j), dn2, 3'(dir_model(64'(frames2[j]), 10, 3, 0)));
      if (j == 0) chk("dut2 axis2", pos2[29:20], 10'h2AA);
      if (j > 0) chk($sformatf("dut2 frame%0d period", j), n, 62);
      p2 = frames2[j];
    end
    done2 = 1;
  end

  initial begin
    int n, first, width;
    logic [15:0] f;
    logic seen;
    tbl[0] = '{16'h0000, 16'h0000, 1'b1, 2'b00, 2'b11};
    tbl[1] = '{16'hA53C, 16'hA53C, 1'b1, 2'b10, 2'b01};
    tbl[2] = '{16'h8090, 16'h8090, 1'b1, 2'b00, 2'b00};
    tbl[3] = '{16'h8090, 16'h8090, 1'b0, 2'b00, 2'b00};
    tbl[4] = '{16'h8091, 16'h8091, 1'b1, 2'b01, 2'b00};
    tbl[5] = '{16'h8070, 16'h8070, 1'b1, 2'b00, 2'b00};
    tbl[6] = '{16'h806F, 16'h806F, 1'b1, 2'b00, 2'b01};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 2'b11, 2'b00};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b0, 2'b11, 2'b00};
    repeat (3) tick();
    chk("reset positions", positions, 16'h8080);
    chk("reset latch/pulse", {latch, pulse}, 2'b00);
    chk("reset strobes", {frame_valid, changed}, 2'b00);
    chk("reset dir", {dir_pos, dir_neg}, 4'b0000);
    reset = 0;
    first = 0;
    width = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (latch) begin
        width++;
        if (first == 0) first = k;
      end
    end
    chk("first latch cycle", first, 5);
    chk("latch width", width, 2);
    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i].f, tbl[i].pos, tbl[i].ch,
                DIR_EN ? tbl[i].dp : 2'b00, DIR_EN ? tbl[i].dn : 2'b00, n);
      if (i > 0) chk($sformatf("vec%0d period", i), n, 71);
    end
    prev = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      f = ($urandom_range(0, 3) == 0) ? prev : 16'($urandom);
      run_frame($sformatf("rand%0d", i), f, f, f != prev, 2'(dir_model(64'(f), 8, 2, 1)),
                2'(dir_model(64'(f), 8, 2, 0)), n);
      chk($sformatf("rand%0d period", i), n, 71);
      prev = f;
    end
    f = 16'h5A0F;
    next_frame = f;
    reach_bit("en_drop", 7);
    enable = 0;
    wait_fv("en_drop", n);
    chk("en_drop positions", positions, f);
    chk("en_drop changed", changed, f != prev);
    next_frame = 16'hC3C3;
    seen = 1'b0;
    repeat (30) begin
      tick();
      seen |= latch;
    end
    chk("latch held off", seen, 1'b0);
    enable = 1;
    tick();
    chk("latch after enable", latch, 1'b1);
    wait_fv("en_resume", n);
    chk("en_resume positions", positions, 16'hC3C3);
    chk("en_resume changed", changed, 1'b1);
    run_frame("pre_abort", 16'hA53C, 16'hA53C, 1'b1, 2'(dir_model(64'hA53C, 8, 2, 1)),
              2'(dir_model(64'hA53C, 8, 2, 0)), n);
    next_frame = 16'h1234;
    reach_bit("abort", 10);
    reset = 1;
    tick();
    reset = 0;
    chk("abort positions", positions, 16'h8080);
    chk("abort latch/pulse", {latch, pulse}, 2'b00);
    chk("abort strobe", frame_valid, 1'b0);
    next_frame = 16'h4321;
    wait_fv("restart", n);
    chk("restart positions", positions, 16'h4321);
    chk("restart changed", changed, 1'b1);
    chk("restart latency", n, 71);
    n = 0;
    while (!done2 && n < 1000) begin tick(); n++; end
    chk("dut2 finished", done2, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
